// File: rtl/fifo_fwft_if.sv
// rtl/fifo_fwft_if.sv - handshake and status bundle for fifo_fwft
interface fifo_fwft_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  clear_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_en_in;
   logic                  full_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  read_en_in;
   logic                  empty_out;
   logic                  almost_full_out;
   logic                  almost_empty_out;
   logic [ADDR_WIDTH:0]   level_out;
   logic [ADDR_WIDTH:0]   free;
   logic                  overflow_out;
   logic                  underflow_out;

   modport master (
      output clear_in, data_in, write_en_in, read_en_in,
      input  full_out, data_out, empty_out, almost_full_out, almost_empty_out,
             level_out, free, overflow_out, underflow_out
   );

   modport slave (
      input  clear_in, data_in, write_en_in, read_en_in,
      output full_out, data_out, empty_out, almost_full_out, almost_empty_out,
             level_out, free, overflow_out, underflow_out
   );
endinterface

// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - single-clock FIFO, registered or first-word-fall-through read
module fifo_fwft #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 1'b0,
   parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input logic        clk,
   input logic        rst,
   fifo_fwft_if.slave bus
);
   localparam int                DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   level;
   logic                  full;
   logic                  empty;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  overflow_q;
   logic                  underflow_q;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] dout_q;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == DEPTH_L);
   assign empty = (level == '0);
   assign head  = mem[rd_ptr[ADDR_WIDTH-1:0]];

   // A pop frees the slot in the same cycle, so a push at full still fits.
   assign rd_ok = bus.read_en_in && !empty && !bus.clear_in;
   assign wr_ok = bus.write_en_in && (!full || rd_ok) && !bus.clear_in;

   always_ff @(posedge clk) begin
      if (wr_ok && rst) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clear_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         if (bus.write_en_in && full && !rd_ok) overflow_q <= 1'b1;
         if (bus.read_en_in && empty) underflow_q <= 1'b1;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Tracks the word on display so it stays visible once the FIFO drains.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout_q <= '0;
            end else if (!empty) begin
               dout_q <= head;
            end
         end
         assign bus.data_out = empty ? dout_q : head;
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout_q <= '0;
            end else if (rd_ok) begin
               dout_q <= head;
            end
         end
         assign bus.data_out = dout_q;
      end
   endgenerate

   assign bus.full_out         = full;
   assign bus.empty_out        = empty;
   assign bus.level_out        = level;
   assign bus.free             = DEPTH_L - level;
   assign bus.almost_full_out  = (level >= AFULL_L);
   assign bus.almost_empty_out = (level <= AEMPTY_L);
   assign bus.overflow_out     = overflow_q;
   assign bus.underflow_out    = underflow_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// tb/tb_fifo_fwft.sv - directed self-checking bench for fifo_fwft, both read modes
module tb_fifo_fwft;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
   fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b_if ();

   fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) u_reg (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) u_fwft (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_op(input logic wr, input logic rd, input logic [7:0] d);
      a_if.write_en_in = wr;
      a_if.read_en_in  = rd;
      a_if.data_in     = d;
      step();
      a_if.write_en_in = 1'b0;
      a_if.read_en_in  = 1'b0;
   endtask

   task automatic b_op(input logic wr, input logic rd, input logic [7:0] d);
      b_if.write_en_in = wr;
      b_if.read_en_in  = rd;
      b_if.data_in     = d;
      step();
      b_if.write_en_in = 1'b0;
      b_if.read_en_in  = 1'b0;
   endtask

   task automatic a_clear();
      a_if.clear_in = 1'b1;
      step();
      a_if.clear_in = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      a_if.clear_in = 1'b0; a_if.data_in = 8'h77; a_if.write_en_in = 1'b1; a_if.read_en_in = 1'b0;
      b_if.clear_in = 1'b0; b_if.data_in = 8'h00; b_if.write_en_in = 1'b0; b_if.read_en_in = 1'b0;
      step();
      step();
      check("rst_level", 32'(a_if.level_out), 0);
      check("rst_free", 32'(a_if.free), 16);
      check("rst_empty", 32'(a_if.empty_out), 1);
      check("rst_full", 32'(a_if.full_out), 0);
      check("rst_aempty", 32'(a_if.almost_empty_out), 1);
      check("rst_afull", 32'(a_if.almost_full_out), 0);
      check("rst_ovf", 32'(a_if.overflow_out), 0);
      check("rst_unf", 32'(a_if.underflow_out), 0);
      check("rst_dout", 32'(a_if.data_out), 0);
      check("rst_b_dout", 32'(b_if.data_out), 0);
      a_if.write_en_in = 1'b0;
      rst = 1'b1;

      a_op(1'b1, 1'b0, 8'hAA);
      check("push_aa_empty", 32'(a_if.empty_out), 0);
      check("push_aa_level", 32'(a_if.level_out), 1);
      a_op(1'b0, 1'b1, 8'h00);
      check("pop_aa_data", 32'(a_if.data_out), 32'hAA);
      check("pop_aa_empty", 32'(a_if.empty_out), 1);
      check("pop_aa_level", 32'(a_if.level_out), 0);

      for (int i = 0; i < 16; i++) begin
         a_op(1'b1, 1'b0, 8'(i));
         check("fill_level", 32'(a_if.level_out), 32'(i + 1));
         check("fill_afull", 32'(a_if.almost_full_out), (i + 1 >= 14) ? 1 : 0);
         check("fill_aempty", 32'(a_if.almost_empty_out), (i + 1 <= 2) ? 1 : 0);
      end
      check("full_flag", 32'(a_if.full_out), 1);
      check("full_free", 32'(a_if.free), 0);
      check("full_ovf_pre", 32'(a_if.overflow_out), 0);
      a_op(1'b1, 1'b0, 8'hFF);
      check("ovf_flag", 32'(a_if.overflow_out), 1);
      check("ovf_level", 32'(a_if.level_out), 16);
      for (int i = 0; i < 16; i++) begin
         a_op(1'b0, 1'b1, 8'h00);
         check("drain_data", 32'(a_if.data_out), 32'(i));
      end
      check("drain_empty", 32'(a_if.empty_out), 1);
      check("ovf_sticky", 32'(a_if.overflow_out), 1);
      a_clear();
      check("clr_ovf", 32'(a_if.overflow_out), 0);

      for (int i = 0; i < 16; i++) a_op(1'b1, 1'b0, 8'(i));
      a_op(1'b1, 1'b1, 8'h5A);
      check("rw_full_data", 32'(a_if.data_out), 0);
      check("rw_full_level", 32'(a_if.level_out), 16);
      check("rw_full_full", 32'(a_if.full_out), 1);
      check("rw_full_ovf", 32'(a_if.overflow_out), 0);
      for (int i = 1; i < 16; i++) begin
         a_op(1'b0, 1'b1, 8'h00);
         check("rw_drain_data", 32'(a_if.data_out), 32'(i));
      end
      a_op(1'b0, 1'b1, 8'h00);
      check("rw_pop16_data", 32'(a_if.data_out), 32'h5A);
      check("rw_pop16_empty", 32'(a_if.empty_out), 1);

      a_op(1'b0, 1'b1, 8'h00);
      check("unf_flag", 32'(a_if.underflow_out), 1);
      check("unf_level", 32'(a_if.level_out), 0);
      check("unf_dout_hold", 32'(a_if.data_out), 32'h5A);
      a_clear();
      check("clr_unf", 32'(a_if.underflow_out), 0);
      check("clr_empty", 32'(a_if.empty_out), 1);

      a_op(1'b1, 1'b1, 8'h33);
      check("rw_empty_level", 32'(a_if.level_out), 1);
      check("rw_empty_unf", 32'(a_if.underflow_out), 1);
      check("rw_empty_dout", 32'(a_if.data_out), 32'h5A);
      a_op(1'b0, 1'b1, 8'h00);
      check("rw_empty_pop", 32'(a_if.data_out), 32'h33);
      a_clear();

      for (int i = 0; i < 32; i++) begin
         a_op(1'b1, 1'b0, 8'(i + 8'h40));
         a_op(1'b0, 1'b1, 8'h00);
         check("wrap_data", 32'(a_if.data_out), 32'(i + 8'h40));
      end
      check("wrap_empty", 32'(a_if.empty_out), 1);

      for (int i = 0; i < 5; i++) a_op(1'b1, 1'b0, 8'(i + 8'h80));
      check("pre_rst_level", 32'(a_if.level_out), 5);
      rst = 1'b0;
      #1;
      check("async_rst_level", 32'(a_if.level_out), 0);
      check("async_rst_empty", 32'(a_if.empty_out), 1);
      check("async_rst_free", 32'(a_if.free), 16);
      step();
      rst = 1'b1;
      a_op(1'b1, 1'b0, 8'h90);
      a_op(1'b0, 1'b1, 8'h00);
      check("post_rst_data", 32'(a_if.data_out), 32'h90);
      check("post_rst_empty", 32'(a_if.empty_out), 1);

      check("b_start_empty", 32'(b_if.empty_out), 1);
      b_op(1'b1, 1'b0, 8'h11);
      check("b_head_11", 32'(b_if.data_out), 32'h11);
      check("b_empty_after_push", 32'(b_if.empty_out), 0);
      b_op(1'b1, 1'b0, 8'h22);
      check("b_head_still_11", 32'(b_if.data_out), 32'h11);
      b_if.read_en_in = 1'b1;
      #1;
      check("b_pre_edge_11", 32'(b_if.data_out), 32'h11);
      step();
      b_if.read_en_in = 1'b0;
      check("b_pop_22", 32'(b_if.data_out), 32'h22);
      check("b_level_1", 32'(b_if.level_out), 1);
      b_op(1'b0, 1'b1, 8'h00);
      check("b_empty_final", 32'(b_if.empty_out), 1);
      check("b_hold_22", 32'(b_if.data_out), 32'h22);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
